// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP transmit arbiter: controller state encoding
// and default length limits.
package udp_arb_pkg;

    localparam int LEN_W_DEF   = 16;
    localparam int MAX_LEN_DEF = 1472;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_START     = 3'd2,
        ST_STREAM    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Request selector: round-robin from ptr+1, or fixed lowest-index-first when
// UDP_ARB_PRIO_EN is defined.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

`ifdef UDP_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    int               c;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef UDP_ARB_PRIO_EN
            c = i;
`else
            c = (int'(ptr) + 1 + i) % NUM_CH;
`endif
            cidx = IDX_W'(c);
            if (!found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares one UDP TX engine between NUM_CH packet sources with an enforced
// inter-packet gap and a stream timeout. Build option: UDP_ARB_PRIO_EN.
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF,
    parameter int GAP_CYCLES = 12,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    rgmii_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH*LEN_W-1:0] ch_len,
    input  logic [NUM_CH*8-1:0]     ch_data,
    output logic [NUM_CH-1:0]       ch_grant,
    output logic [NUM_CH-1:0]       ch_rd_en,
    output logic [NUM_CH-1:0]       ch_done,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [LEN_W-1:0]        tx_len,
    input  logic                    tx_data_req,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic                    err_len,
    output logic                    err_timeout
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  gnt_idx;
    logic [NUM_CH-1:0] arb_onehot;
    logic              arb_found;
    logic [LEN_W-1:0]  arb_len;
    logic [LEN_W-1:0]  gnt_len;
    logic [LEN_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              take;
    logic              rd_vld_p1;
    logic              len_bad;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req   (ch_req),
        .ptr   (ptr),
        .grant (arb_onehot),
        .idx   (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        arb_len = '0;
        tx_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_idx == IDX_W'(i)) arb_len = ch_len[i*LEN_W +: LEN_W];
            if (rd_vld_p1 && gnt_idx == IDX_W'(i)) tx_data = ch_data[i*8 +: 8];
        end
    end

    assign len_bad  = (arb_len == '0) || (arb_len > LEN_W'(MAX_LEN));
    assign take     = (state == ST_STREAM) && tx_data_req && (cnt < tx_len);
    assign ch_rd_en = ch_grant & {NUM_CH{take}};

    always_ff @(posedge rgmii_clk) begin
        if (state == ST_ARB) begin
            gnt_idx <= arb_idx;
            gnt_len <= arb_len;
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NUM_CH - 1);
            ch_grant    <= '0;
            ch_done     <= '0;
            tx_start    <= 1'b0;
            tx_len      <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            rd_vld_p1   <= 1'b0;
        end else begin
            ch_done     <= '0;
            tx_start    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            // request accepted this cycle -> byte on tx_data next cycle
            rd_vld_p1   <= take;
            case (state)
                ST_IDLE: if (|ch_req) state <= ST_ARB;
                ST_ARB: begin
                    if (!arb_found) begin
                        state <= ST_IDLE;
                    end else begin
                        ptr <= arb_idx;
                        if (len_bad) begin
                            err_len <= 1'b1;
                            ch_done <= arb_onehot;
                            state   <= ST_IDLE;
                        end else begin
                            ch_grant <= arb_onehot;
                            state    <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_len   <= gnt_len;
                        cnt      <= '0;
                        tmo_cnt  <= '0;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM, ST_WAIT_DONE: begin
                    // a short frame from the engine ends the packet as well
                    if (tx_done) begin
                        ch_done  <= ch_grant;
                        ch_grant <= '0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        ch_done     <= ch_grant;
                        ch_grant    <= '0;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (take) begin
                            cnt <= cnt + 1'b1;
                            if (cnt + 1'b1 == tx_len) state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: a source model per channel and an engine
// driven from tasks, with hand-computed expectations.
module tb_udp_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 16;

    logic                    rgmii_clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       ch_req;
    logic [NUM_CH*LEN_W-1:0] ch_len;
    logic [NUM_CH*8-1:0]     ch_data;
    logic [NUM_CH-1:0]       ch_grant, ch_rd_en, ch_done;
    logic                    tx_ready, tx_start, tx_data_req, tx_done;
    logic [LEN_W-1:0]        tx_len;
    logic [7:0]              tx_data;
    logic                    err_len, err_timeout;

    always #5 rgmii_clk = ~rgmii_clk;

    udp_tx_arbiter #(
        .NUM_CH(NUM_CH), .LEN_W(LEN_W), .MAX_LEN(1472), .GAP_CYCLES(12), .TIMEOUT(100)
    ) dut (
        .rgmii_clk(rgmii_clk), .rst(rst), .ch_req(ch_req), .ch_len(ch_len),
        .ch_data(ch_data), .ch_grant(ch_grant), .ch_rd_en(ch_rd_en), .ch_done(ch_done),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_len(tx_len),
        .tx_data_req(tx_data_req), .tx_data(tx_data), .tx_done(tx_done),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge rgmii_clk) cyc <= cyc + 1;

    // Source model: byte k of a packet from channel i is src_base[i] + k.
    logic [7:0] src_base [NUM_CH] = '{8'h10, 8'hA0, 8'h20, 8'h30};
    int         src_idx  [NUM_CH];
    logic       src_clr = 1'b0;
    always @(posedge rgmii_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_clr) src_idx[i] <= 0;
            else if (ch_rd_en[i]) begin
                ch_data[i*8 +: 8] <= src_base[i] + 8'(src_idx[i]);
                src_idx[i]        <= src_idx[i] + 1;
            end
        end
    end

    task automatic clr_src();
        src_clr = 1'b1;
        @(negedge rgmii_clk);
        src_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rgmii_clk);
    endtask

    task automatic set_req(input int ch, input int len);
        ch_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
        ch_req[ch] = 1'b1;
    endtask

    task automatic wait_start(output int at, input int bound);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge rgmii_clk);
            if (tx_start) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL wait_start: no tx_start within %0d cycles", bound);
        end
    endtask

    task automatic stream(input int ch, input int len, input int nreq);
        logic [NUM_CH-1:0] exp_rd;
        logic [7:0]        exp_d;
        for (int k = 0; k <= nreq; k++) begin
            if (k > 0) begin
                @(negedge rgmii_clk);
                exp_d = (k - 1 < len) ? src_base[ch] + 8'(k - 1) : 8'h00;
                checks++;
                if (tx_data !== exp_d) begin
                    errors++;
                    $display("FAIL tx_data ch%0d byte%0d: got %h want %h", ch, k - 1, tx_data, exp_d);
                end
            end
            if (k < nreq) begin
                tx_data_req = 1'b1;
                #1;
                exp_rd = (k < len) ? (NUM_CH'(1) << ch) : '0;
                checks++;
                if (ch_rd_en !== exp_rd) begin
                    errors++;
                    $display("FAIL ch_rd_en ch%0d req%0d: got %b want %b", ch, k, ch_rd_en, exp_rd);
                end
            end else begin
                tx_data_req = 1'b0;
            end
        end
    endtask

    task automatic send_done(input int ch, output int at);
        tx_done = 1'b1;
        at = cyc;
        @(negedge rgmii_clk);
        tx_done = 1'b0;
        checks++;
        if (ch_done !== (NUM_CH'(1) << ch) || ch_grant !== '0) begin
            errors++;
            $display("FAIL done ch%0d: ch_done=%b ch_grant=%b want done=%b grant=0",
                     ch, ch_done, ch_grant, NUM_CH'(1) << ch);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({ch_grant, ch_rd_en, ch_done, tx_start, tx_len, err_len, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset outputs: grant=%b rd=%b done=%b start=%b len=%0d el=%b et=%b",
                     ch_grant, ch_rd_en, ch_done, tx_start, tx_len, err_len, err_timeout);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        int t_s, t_d;
        bit early;
        clr_src();
        tx_ready = 1'b0;
        set_req(1, 4);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rgmii_clk);
            if (tx_start) early = 1'b1;
        end
        checks++;
        if (early || ch_grant !== 4'b0010) begin
            errors++;
            $display("FAIL start_hold: early_start=%b grant=%b want 0/0010", early, ch_grant);
        end
        tx_ready = 1'b1;
        wait_start(t_s, 10);
        ch_req[1] = 1'b0;
        checks++;
        if (tx_len !== 16'd4) begin
            errors++;
            $display("FAIL single tx_len: got %0d want 4", tx_len);
        end
        stream(1, 4, 4);
        checks++;
        if (tx_len !== 16'd4) begin
            errors++;
            $display("FAIL single tx_len_stable: got %0d want 4", tx_len);
        end
        send_done(1, t_d);
        idle(16);
    endtask

    task automatic test_rr();
        int t_s, t_d;
        logic [NUM_CH-1:0] exp_g [3] = '{4'b0001, 4'b0100, 4'b0001};
        int                exp_c [3] = '{0, 2, 0};
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        set_req(0, 8);
        set_req(2, 8);
        t_d = 0;
        for (int p = 0; p < 3; p++) begin
            clr_src();
            wait_start(t_s, 40);
            checks++;
            if (ch_grant !== exp_g[p]) begin
                errors++;
                $display("FAIL rr grant pkt%0d: got %b want %b", p, ch_grant, exp_g[p]);
            end
            if (p > 0) begin
                checks++;
                if (t_s - t_d < 13) begin
                    errors++;
                    $display("FAIL rr gap pkt%0d: done->start %0d cycles want >=13", p, t_s - t_d);
                end
            end
            stream(exp_c[p], 8, 8);
            if (p == 2) ch_req = '0;
            send_done(exp_c[p], t_d);
        end
        idle(16);
    endtask

    task automatic test_len_err(input int len);
        bit seen, started;
        seen = 1'b0;
        started = 1'b0;
        set_req(3, len);
        for (int i = 0; i < 10; i++) begin
            @(negedge rgmii_clk);
            if (tx_start) started = 1'b1;
            if (err_len) begin
                seen = 1'b1;
                ch_req[3] = 1'b0;
                checks++;
                if (ch_done !== 4'b1000) begin
                    errors++;
                    $display("FAIL len_err ch_done len=%0d: got %b want 1000", len, ch_done);
                end
                break;
            end
        end
        ch_req[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rgmii_clk);
            if (tx_start) started = 1'b1;
        end
        checks++;
        if (!seen || started) begin
            errors++;
            $display("FAIL len_err len=%0d: err_len_seen=%b tx_start_seen=%b want 1/0", len, seen, started);
        end
    endtask

    task automatic test_extra_req();
        int t_s, t_d;
        clr_src();
        set_req(1, 4);
        wait_start(t_s, 20);
        ch_req[1] = 1'b0;
        stream(1, 4, 6);
        send_done(1, t_d);
        idle(16);
    endtask

    task automatic test_timeout();
        int t_s, t_e, t_d;
        clr_src();
        set_req(2, 4);
        wait_start(t_s, 20);
        ch_req[2] = 1'b0;
        stream(2, 4, 4);
        t_e = -1;
        for (int i = 0; i < 150; i++) begin
            if (err_timeout) begin
                t_e = cyc;
                break;
            end
            @(negedge rgmii_clk);
        end
        checks++;
        if (t_e - t_s != 100) begin
            errors++;
            $display("FAIL timeout cycle: err_timeout %0d cycles after tx_start want 100", t_e - t_s);
        end
        checks++;
        if (ch_done !== 4'b0100) begin
            errors++;
            $display("FAIL timeout ch_done: got %b want 0100", ch_done);
        end
        clr_src();
        set_req(1, 2);
        wait_start(t_s, 40);
        ch_req[1] = 1'b0;
        checks++;
        if (ch_grant !== 4'b0010) begin
            errors++;
            $display("FAIL after_timeout grant: got %b want 0010", ch_grant);
        end
        stream(1, 2, 2);
        send_done(1, t_d);
        idle(16);
    endtask

    task automatic test_reset_mid();
        int t_s, t_d;
        clr_src();
        set_req(1, 4);
        wait_start(t_s, 20);
        tx_data_req = 1'b1;
        rst = 1'b1;
        @(negedge rgmii_clk);
        checks++;
        if ({ch_grant, ch_rd_en, ch_done, tx_start, tx_len, err_len, err_timeout, tx_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: grant=%b rd=%b done=%b start=%b len=%0d data=%h",
                     ch_grant, ch_rd_en, ch_done, tx_start, tx_len, tx_data);
        end
        rst = 1'b0;
        tx_data_req = 1'b0;
        ch_req = '0;
        clr_src();
        set_req(2, 2);
        set_req(0, 2);
        wait_start(t_s, 20);
        ch_req = '0;
        checks++;
        if (ch_grant !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset grant: got %b want 0001", ch_grant);
        end
        stream(0, 2, 2);
        send_done(0, t_d);
        idle(16);
    endtask

    initial begin
        rst = 1'b1;
        ch_req = '0;
        ch_len = '0;
        tx_ready = 1'b0;
        tx_data_req = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_len_err(0);
        test_len_err(1500);
        test_extra_req();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares one UDP transmit engine between NUM_CH independent packet sources.
- Each source raises a request with a payload length. The block arbitrates round-robin, starts the engine, and forwards the granted source's bytes on the engine's data-request strobe.
- Then waits for frame completion and enforces a minimum inter-packet gap.
- Sits between application channels (sensor/loopback/status FIFOs) and the UDP/IP/MAC TX path in the rgmii_clk domain.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- LEN_W, 16, payload length width, matches UDP length field.
- MAX_LEN, 1472, largest legal payload in bytes; larger is rejected.
- GAP_CYCLES, 12, idle cycles forced after each tx_done before next arbitration.
- TIMEOUT, 65535, cycles allowed in STREAM+WAIT_DONE before abort.

Ports:
- rgmii_clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel packet pending; ch_len/ch_data valid while high.
- ch_len  in  NUM_CH*LEN_W  packed payload lengths, channel i at [i*LEN_W +: LEN_W].
- ch_data  in  NUM_CH*8  packed read data, valid one cycle after ch_rd_en.
- ch_grant  out  NUM_CH  one-hot grant, held START..WAIT_DONE.
- ch_rd_en  out  NUM_CH  byte read strobe to granted source.
- ch_done  out  NUM_CH  one-cycle completion pulse (sent, rejected or aborted).
- tx_ready  in  1  engine idle, can accept tx_start.
- tx_start  out  1  one-cycle start pulse to engine.
- tx_len  out  LEN_W  payload length, stable from tx_start until tx_done.
- tx_data_req  in  1  engine byte request; data expected next cycle.
- tx_data  out  8  payload byte to engine.
- tx_done  in  1  engine frame-complete pulse.
- err_len  out  1  pulse: granted request had length 0 or >MAX_LEN.
- err_timeout  out  1  pulse: TIMEOUT expired, packet aborted.

Behaviour:
- Reset: state IDLE; ch_grant, ch_rd_en, ch_done, tx_start, tx_len, err_* all 0; RR pointer = NUM_CH-1 (ch0 highest first); counters 0. rst mid-packet drops everything next edge, no ch_done.
- States: IDLE -> ARB -> START -> STREAM -> WAIT_DONE -> GAP -> IDLE.
- IDLE: to ARB when |ch_req.
- ARB (1 cycle): select first requesting channel scanning from pointer+1 modulo NUM_CH; latch index and length; pointer := winner.
  - If length 0 or >MAX_LEN: pulse err_len and ch_done[winner], go IDLE.
  - Otherwise go START.
- START: wait for tx_ready; then pulse tx_start one cycle with tx_len = latched length, byte counter := 0, go STREAM.
- STREAM: ch_rd_en[g] = tx_data_req && cnt < tx_len, combinational. Each accepted request increments cnt.
  - tx_data = ch_data[g] registered-through-mux, valid cycle after request.
  - Requests beyond tx_len are ignored and tx_data = 8'h00.
  - When cnt reaches tx_len, go WAIT_DONE.
- WAIT_DONE: on tx_done, pulse ch_done[g], drop grant, go GAP.
  - tx_done arriving in STREAM (engine short frame) is treated identically.
- GAP: count GAP_CYCLES then IDLE; requests during GAP are held, not lost.
- Timeout: cycle counter runs in STREAM/WAIT_DONE. At TIMEOUT, pulse err_timeout and ch_done[g], go GAP.
- ch_req deassert while granted is ignored; grant runs to completion.
- Simultaneous requests always resolve by RR pointer; no channel waits more than NUM_CH-1 packets.

Optional Feature:
- UDP_ARB_PRIO_EN defined: ARB uses fixed priority, lowest index wins, pointer unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package udp_arb_pkg: state encoding constants, LEN_W default, MAX_LEN default.
- One natural sub-module: rr_arbiter, which takes req vector and pointer and gives one-hot grant plus index.
  - Parameterised NUM_CH.
  - Contains the PRIO_EN mux.

Test Plan:
- ch1 req len=4, bytes A0..A3 -> one tx_start, tx_len=4, tx_data A0,A1,A2,A3 each one cycle after tx_data_req, ch_done[1] after tx_done.
- ch0 and ch2 both requesting, len=8 each, held -> grants alternate ch0,ch2,ch0 with ≥12 idle cycles between tx_done and next tx_start.
- ch3 len=0, then len=1500 -> err_len pulse and ch_done[3] each time, no tx_start.
- Engine issues 6 tx_data_req for len=4 -> only 4 ch_rd_en, extra bytes 0x00, counter stops at 4.
- tx_done withheld, TIMEOUT=100 -> err_timeout and ch_done at cycle 100 of STREAM/WAIT_DONE, then GAP, then next request served.
- rst asserted mid-STREAM -> next edge all outputs 0, state IDLE, next request served starting ch0; with UDP_ARB_PRIO_EN, ch0 always beats ch2.
